// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, FSM encoding and
// the layout of a queued command record.
package alu_issue_pkg;

    // ALU opcodes. The issuer forwards all eight values uninterpreted.
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_GT   = 3'b101;
    localparam logic [2:0] OP_SHLA = 3'b110;
    localparam logic [2:0] OP_SHLB = 3'b111;

    // Issuer FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam int OPCODE_W = 3;

    // Command record, MSB to LSB: {opcode, a, b, tag}.
    // Default-width view of the record, for reference and for benches.
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [7:0]          a;
        logic [7:0]          b;
        logic [3:0]          tag;
    } cmd_rec_t;

    // Width of a command record for a given operand and tag width.
    function automatic int cmd_width(input int n, input int tag_w);
        return OPCODE_W + 2 * n + tag_w;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with first-word-fall-through read: rdata_o always shows
// the head entry so the consumer can load it on the same edge it pops.
module alu_cmd_fifo #(
    parameter int W     = 31,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full/empty gating lives here so callers cannot corrupt the pointers.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage array: no reset needed, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command issuer for the combinational 8-bit ALU: queues commands, drives
// operands for one settle cycle, then returns the registered result and
// flags on a tagged valid/ready response stream.
module alu_cmd_issuer
    import alu_issue_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opcode,
    input  logic [N-1:0]     cmd_a,
    input  logic [N-1:0]     cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [N-1:0]     alu_result,
    input  logic             alu_z_flag,
    input  logic             alu_c_flag,
    input  logic             alu_c_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_result,
    output logic             rsp_z,
    output logic             rsp_c,
    output logic             rsp_cout,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int CMD_W = cmd_width(N, TAG_W);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic [CMD_W-1:0] fifo_wdata;
    logic [CMD_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             pop;
    logic             rsp_hs;

    logic [2:0]       head_opcode;
    logic [N-1:0]     head_a;
    logic [N-1:0]     head_b;
    logic [TAG_W-1:0] head_tag;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     alu_a_q, alu_b_q;
    logic [2:0]       alu_opcode_q;
    logic [TAG_W-1:0] tag_q;
    logic             rsp_valid_q;
    logic [N-1:0]     rsp_result_q;
    logic             rsp_z_q, rsp_c_q, rsp_cout_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [15:0]      op_count_q;

    assign fifo_wdata = {cmd_opcode, cmd_a, cmd_b, cmd_tag};
    assign {head_opcode, head_a, head_b, head_tag} = fifo_rdata;

    alu_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Ready depends only on the stored count: a pop on a full FIFO does not
    // open a slot for a push in the same cycle.
    assign cmd_ready = !fifo_full;
    assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);
    assign rsp_hs    = rsp_valid_q && rsp_ready;

    // Next-state and pop decision: pop from IDLE, or chain straight from a
    // completed response into the next DRIVE.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand and response registers; operands change only on pop,
    // responses are captured at the edge ending DRIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= OP_ADD;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_z_q      <= 1'b0;
            rsp_c_q      <= 1'b0;
            rsp_cout_q   <= 1'b0;
            rsp_tag_q    <= '0;
            op_count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                alu_a_q      <= head_a;
                alu_b_q      <= head_b;
                alu_opcode_q <= head_opcode;
                tag_q        <= head_tag;
            end
            if (state_q == ST_DRIVE) begin
                rsp_valid_q  <= 1'b1;
                rsp_result_q <= alu_result;
                rsp_z_q      <= alu_z_flag;
                rsp_c_q      <= alu_c_flag;
                rsp_cout_q   <= alu_c_out;
                rsp_tag_q    <= tag_q;
            end else if (rsp_hs) begin
                rsp_valid_q  <= 1'b0;
            end
            if (rsp_hs) begin
                op_count_q <= op_count_q + 16'd1;
            end
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_z      = rsp_z_q;
    assign rsp_c      = rsp_c_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_tag    = rsp_tag_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a behavioural ALU closes the loop, commands push
// their expected response into a scoreboard and a monitor checks responses.
module tb_alu_cmd_issuer;
    import alu_issue_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_opcode;
    logic [7:0] cmd_a, cmd_b;
    logic [3:0] cmd_tag;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_result;
    logic       alu_z_flag, alu_c_flag, alu_c_out;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_z, rsp_c, rsp_cout;
    logic [3:0] rsp_tag;
    logic       busy;
    logic [15:0] op_count;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b;
        logic [3:0] tag;
        logic [7:0] res;
        logic       z, c, cout;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    bit   rand_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_issuer #(.N(8), .DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_z_flag(alu_z_flag),
        .alu_c_flag(alu_c_flag), .alu_c_out(alu_c_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_cout(rsp_cout), .rsp_tag(rsp_tag),
        .busy(busy), .op_count(op_count)
    );

    // Reference ALU: returns {result, z, c, cout}.
    function automatic logic [10:0] alu_ref(input logic [2:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        w = 9'd0;
        case (op)
            OP_ADD:  w = {1'b0, a} + {1'b0, b};
            OP_SUB:  w = {1'b0, a} - {1'b0, b};
            OP_AND:  w = {1'b0, a & b};
            OP_OR:   w = {1'b0, a | b};
            OP_XOR:  w = {1'b0, a ^ b};
            OP_GT:   w = (a > b) ? 9'h101 : 9'h000;
            OP_SHLA: w = {a, 1'b0};
            default: w = {b, 1'b0};
        endcase
        r = w[7:0];
        c = w[8];
        return {r, (r == 8'd0), c, c};
    endfunction

    always_comb begin
        {alu_result, alu_z_flag, alu_c_flag, alu_c_out} = alu_ref(alu_opcode, alu_a, alu_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_exp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] tag, input logic [7:0] res,
                            input logic z, input logic c, input logic cout);
        exp_t e;
        int   w;
        cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        e.op = op; e.a = a; e.b = b; e.tag = tag;
        e.res = res; e.z = z; e.c = c; e.cout = cout;
        sb.push_back(e);
        $display("cmd  tag=%0d op=%0d a=0x%02h b=0x%02h exp_res=0x%02h", tag, op, a, b, res);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_model(input logic [2:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [3:0] tag);
        logic [10:0] r;
        r = alu_ref(op, a, b);
        send_exp(op, a, b, tag, r[10:3], r[2], r[1], r[0]);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || rsp_valid) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on each handshake, checks operand
    // stability while a response is pending and payload stability under stall.
    initial begin
        exp_t          e;
        bit            hold = 1'b0;
        logic [15:0]   held;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                chk("stall_valid", 32'(rsp_valid), 32'd1);
                chk("stall_payload", 32'({rsp_result, rsp_z, rsp_c, rsp_cout, rsp_tag}), 32'(held));
            end
            if (rsp_valid && sb.size() != 0)
                chk("alu_operands_stable", 32'({alu_opcode, alu_a, alu_b}),
                    32'({sb[0].op, sb[0].a, sb[0].b}));
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_rsp: got tag %0d expected none", rsp_tag);
                end else begin
                    e = sb.pop_front();
                    $display("rsp  tag=%0d res=0x%02h z=%0d c=%0d cout=%0d", rsp_tag, rsp_result,
                             rsp_z, rsp_c, rsp_cout);
                    chk($sformatf("rsp_tag%0d", e.tag),
                        32'({rsp_result, rsp_z, rsp_c, rsp_cout, rsp_tag}),
                        32'({e.res, e.z, e.c, e.cout, e.tag}));
                end
            end
            hold = rsp_valid && !rsp_ready;
            held = {rsp_result, rsp_z, rsp_c, rsp_cout, rsp_tag};
        end
    end

    task automatic chk_reset_outputs(input string tagname);
        chk({tagname, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tagname, "_rsp"}, 32'({rsp_valid, rsp_result, rsp_z, rsp_c, rsp_cout, rsp_tag}), 32'd0);
        chk({tagname, "_alu"}, 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        chk({tagname, "_busy"}, 32'(busy), 32'd0);
        chk({tagname, "_op_count"}, 32'(op_count), 32'd0);
    endtask

    initial begin
        int hs_cyc[$];
        int w;
        bit seen;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_opcode = 3'd0; cmd_a = 8'd0; cmd_b = 8'd0; cmd_tag = 4'd0;
        #3;
        chk_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: ADD F0+20, latency of two edges.
        rsp_ready = 1'b1;
        send_exp(OP_ADD, 8'hF0, 8'h20, 4'd3, 8'h10, 1'b0, 1'b1, 1'b1);
        chk("t1_no_pop_yet", 32'({rsp_valid, alu_a}), 32'd0);
        @(negedge clk);
        chk("t1_alu_loaded", 32'({alu_opcode, alu_a, alu_b}), 32'({OP_ADD, 8'hF0, 8'h20}));
        chk("t1_rsp_not_yet", 32'(rsp_valid), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_result", 32'(rsp_result), 32'h10);
        @(negedge clk);
        chk("t1_op_count", 32'(op_count), 32'd1);
        chk("t1_idle", 32'({rsp_valid, busy}), 32'd0);

        // 2: SUB 5-5 with two stall cycles in RESP.
        rsp_ready = 1'b0;
        send_exp(OP_SUB, 8'h05, 8'h05, 4'd4, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_alu_drive", 32'({alu_opcode, alu_a, alu_b}), 32'({OP_SUB, 8'h05, 8'h05}));
        @(negedge clk); @(negedge clk); @(negedge clk);
        rsp_ready = 1'b1;
        drain();
        chk("t2_op_count", 32'(op_count), 32'd2);

        // 3: backpressure, 1 in flight plus 4 queued, 6th refused.
        rsp_ready = 1'b0;
        send_exp(OP_OR,   8'h0F, 8'hF0, 4'd1, 8'hFF, 1'b0, 1'b0, 1'b0);
        send_exp(OP_AND,  8'hAA, 8'h0F, 4'd2, 8'h0A, 1'b0, 1'b0, 1'b0);
        send_exp(OP_XOR,  8'hFF, 8'hFF, 4'd3, 8'h00, 1'b1, 1'b0, 1'b0);
        send_exp(OP_GT,   8'h80, 8'h7F, 4'd4, 8'h01, 1'b0, 1'b1, 1'b1);
        send_exp(OP_SHLA, 8'h81, 8'h00, 4'd5, 8'h02, 1'b0, 1'b1, 1'b1);
        chk("t3_full", 32'(cmd_ready), 32'd0);
        cmd_opcode = OP_SHLB; cmd_a = 8'h00; cmd_b = 8'h40; cmd_tag = 4'd6; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_sixth_refused", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        chk("t3_head_held", 32'({rsp_valid, rsp_tag}), 32'({1'b1, 4'd1}));
        rsp_ready = 1'b1;
        w = 0;
        while (hs_cyc.size() < 5 && w < 40) begin
            if (rsp_valid) hs_cyc.push_back(cyc);
            @(negedge clk);
            w++;
        end
        chk("t3_drained5", 32'(hs_cyc.size()), 32'd5);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("t3_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);
        drain();
        chk("t3_op_count", 32'(op_count), 32'd7);

        // 4: 20 random commands under random rsp_ready.
        rand_en = 1'b1;
        fork
            begin
                while (rand_en) begin
                    @(negedge clk);
                    if (rand_en) rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 20; i++)
            send_model(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 4'(i));
        drain();
        rand_en = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
        chk("t4_op_count", 32'(op_count), 32'd27);

        // 5: reset while in DRIVE with three commands queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send_model(OP_ADD, 8'(i * 16), 8'h01, 4'(7 + i));
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t5_in_drive", 32'({busy, rsp_valid}), 32'({1'b1, 1'b0}));
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk_reset_outputs("t5_async_reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("t5_no_rsp_after_reset", 32'(seen), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);

        // 6: op_count wrap from 0xFFFF.
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        @(negedge clk);
        chk("t6_preload", 32'(op_count), 32'hFFFF);
        send_exp(OP_ADD, 8'h01, 8'hFF, 4'd15, 8'h00, 1'b1, 1'b1, 1'b1);
        drain();
        @(negedge clk);
        chk("t6_wrap", 32'(op_count), 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Sequential initiator that drives the team's combinational 8-bit ALU port (A, B, OpCode in; Result, Z_flag, C_flag, C_out out). It accepts operation commands over a valid/ready stream, buffers them in a small FIFO, and presents each command's operands to the ALU for one settle cycle. It then registers the result and flags and returns them on a tagged valid/ready response stream. It sits between a command source (test controller or microsequencer) and the ALU instance.

## Interface
- N, 8, operand/result width; must match the ALU instance
- DEPTH, 4, command FIFO depth; power of two, ≥2
- TAG_W, 4, width of the command/response tag
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_opcode  in  3  ALU opcode
- cmd_a, cmd_b  in  N  operands
- cmd_tag  in  TAG_W  caller tag, returned unchanged
- alu_a, alu_b  out  N  registered operands to ALU
- alu_opcode  out  3  registered opcode to ALU
- alu_result  in  N  ALU Result
- alu_z_flag, alu_c_flag, alu_c_out  in  1  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  N  captured result
- rsp_z, rsp_c, rsp_cout  out  1  captured flags
- rsp_tag  out  TAG_W  tag of the completed command
- busy  out  1  FSM not IDLE or FIFO not empty
- op_count  out  16  completed responses, wraps 0xFFFF→0x0000

## Operation
- Push when cmd_valid && cmd_ready. cmd_ready = (count != DEPTH) and depends only on the current count, so a same-cycle pop does not admit a push when full.
- The FIFO stores {opcode, a, b, tag}. Count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- All opcodes 000–111 are legal and are passed through uninterpreted.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head, load alu_a/alu_b/alu_opcode and the tag register, and go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: one cycle for the ALU to settle. At the edge ending DRIVE, capture alu_result and the three flags into the rsp_* registers, set rsp_valid, and go to RESP.
  - RESP: hold rsp_* stable while !rsp_ready. On rsp_valid && rsp_ready, increment op_count and clear rsp_valid. Then, if FIFO is non-empty, pop the next command into alu_* and go to DRIVE; otherwise go to IDLE.
- alu_a, alu_b and alu_opcode change only on a pop. They are stable throughout DRIVE and RESP.
- A push and a pop in the same cycle leave count unchanged.
- Reset (asynchronous, any state):
  - FSM returns to IDLE, FIFO is emptied, and no in-flight response survives.
  - Output values during reset: cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_z/rsp_c/rsp_cout=0, rsp_tag=0, alu_a/alu_b=0, alu_opcode=000, busy=0, op_count=0.

## Timing
- Command accepted at edge E0 into an empty, idle block:
  - pop at E1 (alu_* valid after E1)
  - capture at E2
  - rsp_valid high after E2
- Latency is 2 edges from accept to response.
- Maximum throughput is one response per 2 cycles, with rsp_ready held high and the FIFO non-empty.
- rsp_valid, once high, stays high with constant payload until the handshake edge.
- ALU path: alu_* register → ALU combinational → rsp_* register, a single-cycle path.
- busy is combinational from the state and count.

## Structure
- Package alu_issue_pkg holds:
  - opcode constants OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_GT=101, OP_SHLA=110, OP_SHLB=111
  - FSM state encoding: IDLE, DRIVE, RESP
  - the command record layout
- Sub-module alu_cmd_fifo: synchronous FIFO with asynchronous active-low reset, parameterised by width and DEPTH, exposing full, empty and count.
- The top level contains the FSM, the operand/response registers and op_count.

## Test plan
- ADD, A=0xF0, B=0x20, tag 3, rsp_ready=1 → after 2 edges: rsp_result=0x10, rsp_cout=1, rsp_c=1, rsp_z=0, rsp_tag=3, op_count=1.
- SUB, A=0x05, B=0x05 → rsp_result=0x00, rsp_z=1, rsp_c=0; alu_* stable across DRIVE and RESP.
- rsp_ready=0, push 5 commands with DEPTH=4:
  - cmd_ready drops after the 4th FIFO entry (1 in flight plus 4 queued)
  - the 6th push is refused
  - raising rsp_ready drains 5 responses in tag order, 2 cycles apart
- Back-to-back stream of 20 random commands, random rsp_ready → every response matches a reference ALU model, tags are in order, and no payload changes while rsp_valid && !rsp_ready.
- Assert rst_n low in DRIVE with 3 commands queued → all outputs take their reset values immediately; after release, busy=0 and no response appears.
- Preload op_count=0xFFFF (force or 65535 ops), complete one more → op_count=0x0000.
